keyrom_reader: RTL and testbench
================================

KEYROM_READER -- requirements
Module: keyrom_reader

Interface
REQ-001 Parameter: ADDR_MSB, 4, MSB of key ROM word address.
REQ-002 Parameter: KEY_WORDS, 10, number of 16-bit key words streamed per read; range 1..2**(ADDR_MSB+1).
REQ-003 mclk  in  1  single clock; all state SHALL update on rising edge only.
REQ-004 puc_rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  one-cycle request to stream the key; ignored unless IDLE.
REQ-006 key_access_ok  in  1  access grant (CPU executing in attestation region); must stay high for whole read.
REQ-007 rom_addr  out  ADDR_MSB+1  key ROM word address.
REQ-008 rom_cen  out  1  key ROM chip enable, active-low.
REQ-009 rom_dout  in  16  key ROM data; valid the cycle after rom_cen=0 with a given rom_addr.
REQ-010 key_data  out  16  key word to consumer.
REQ-011 key_valid  out  1  key_data valid.
REQ-012 key_ready  in  1  consumer accepts; transfer when key_valid&key_ready.
REQ-013 key_last  out  1  high with key_valid on final word (index KEY_WORDS-1).
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 done  out  1  one-cycle pulse after final word transfers.
REQ-016 err  out  1  one-cycle pulse on access-violation abort.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, CAPTURE, OUT, DONE.
REQ-018 IDLE: rom_cen=1; on start&key_access_ok -> ISSUE with word index idx=0; on start&!key_access_ok -> stay IDLE, pulse err next cycle.
REQ-019 ISSUE: rom_cen=0, rom_addr=idx for exactly one cycle -> CAPTURE.
REQ-020 CAPTURE: rom_cen=1; key_data SHALL register rom_dout at end of cycle -> OUT.
REQ-021 OUT: key_valid=1, key_data stable until transfer; key_last=1 iff idx==KEY_WORDS-1.
REQ-022 OUT on transfer: if idx==KEY_WORDS-1 -> DONE, else idx<=idx+1 -> ISSUE.
REQ-023 DONE: done=1 for one cycle -> IDLE; idx SHALL return to 0.
REQ-024 Latency: start at cycle N -> first key_valid at cycle N+3; with key_ready held high, one word per 3 cycles; full stream of KEY_WORDS words, done at N+3*KEY_WORDS+1.
REQ-025 idx SHALL be ADDR_MSB+1 bits and never exceed KEY_WORDS-1 (no wrap).
REQ-026 key_access_ok low in any state other than IDLE/DONE: next state IDLE, err pulses one cycle, key_valid=0 next cycle, no done pulse, no further ROM access.
REQ-027 Abort has priority over a simultaneous transfer in OUT; that word counts as not delivered.
REQ-028 start while busy SHALL be ignored with no effect on state or idx.
REQ-029 rom_cen SHALL be low only in ISSUE; rom_addr SHALL be 0 whenever rom_cen=1.

Reset
REQ-030 puc_rst high: state IDLE, idx=0, rom_cen=1, rom_addr=0, key_data=0, key_valid=0, key_last=0, busy=0, done=0, err=0 at next edge.
REQ-031 Reset mid-stream SHALL abandon the read with no done/err pulse; reset dominates start and key_access_ok.

Configuration
REQ-032 Macro KEYRD_SCRUB_EN defined: key_data SHALL be cleared to 0 in the cycle after each transfer, abort, or DONE; key_data nonzero only while key_valid=1.
REQ-033 Macro KEYRD_SCRUB_EN undefined: key_data SHALL hold the last captured word until the next CAPTURE or reset.

Verification
REQ-034 ROM words 0123,4567,89ab,cdef,0..; start pulse, key_ready=1 -> key_valid at +3, words 0123,4567,89ab,cdef,0000x6 in order, key_last on 10th, done at +31.
REQ-035 key_ready low for 5 cycles in OUT on word 2 -> key_data=89ab held stable, rom_cen stays 1, stream resumes unchanged.
REQ-036 key_access_ok dropped in OUT of word 3 with key_ready=1 -> err pulse, key_valid=0 next cycle, no done, busy=0, restart yields word 0123 first.
REQ-037 start with key_access_ok=0 -> err pulse, rom_cen never low, busy stays 0.
REQ-038 puc_rst in CAPTURE of word 5 -> all outputs reset values next cycle, no done/err; start while busy on a fresh run ignored.
REQ-039 With KEYRD_SCRUB_EN: key_data=0000 cycle after each transfer; without: key_data=cdef persists after word 3 transfer until next CAPTURE.

Source files
------------

// File: rtl/keyrom_reader.sv
// Streams KEY_WORDS 16-bit key words from a synchronous key ROM to a ready/valid consumer,
// aborting on loss of access grant. Define KEYRD_SCRUB_EN to zero key_data once each word is consumed.
module keyrom_reader #(
    parameter int ADDR_MSB  = 4,
    parameter int KEY_WORDS = 10
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              start,
    input  logic              key_access_ok,
    output logic [ADDR_MSB:0] rom_addr,
    output logic              rom_cen,
    input  logic [15:0]       rom_dout,
    output logic [15:0]       key_data,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef KEYRD_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    localparam logic [ADDR_MSB:0] LAST_IDX = (ADDR_MSB + 1)'(KEY_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_MSB:0] idx_q, idx_d;
    logic [15:0]       key_data_q, key_data_d;
    logic              err_q, err_d;
    logic              xfer;
    logic              at_last;

    assign xfer    = (state_q == S_OUT) && key_ready;
    assign at_last = (idx_q == LAST_IDX);

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            key_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            key_data_q <= key_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        key_data_d = key_data_q;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (key_access_ok) begin
                        state_d = S_ISSUE;
                        idx_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d    = S_OUT;
                key_data_d = rom_dout;
            end
            S_OUT: begin
                if (xfer) begin
                    if (SCRUB) key_data_d = '0;
                    if (at_last) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
                if (SCRUB) key_data_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        // Losing the grant mid-read wins over any transfer in the same cycle.
        if (!key_access_ok && (state_q inside {S_ISSUE, S_CAPTURE, S_OUT})) begin
            state_d = S_IDLE;
            idx_d   = '0;
            err_d   = 1'b1;
            if (SCRUB) key_data_d = '0;
        end
    end

    always_comb begin
        rom_cen   = (state_q != S_ISSUE);
        rom_addr  = (state_q == S_ISSUE) ? idx_q : '0;
        key_valid = (state_q == S_OUT);
        key_last  = (state_q == S_OUT) && at_last;
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        err       = err_q;
        key_data  = key_data_q;
    end

endmodule

// File: tb/tb_keyrom_reader.sv
// Directed bench for keyrom_reader: full stream, backpressure, access abort,
// denied start, mid-stream reset, start-while-busy and key_data retention/scrub.
module tb_keyrom_reader;

    localparam int ADDR_MSB  = 4;
    localparam int KEY_WORDS = 10;

`ifdef KEYRD_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    logic              mclk = 1'b0;
    logic              puc_rst;
    logic              start;
    logic              key_access_ok;
    logic [ADDR_MSB:0] rom_addr;
    logic              rom_cen;
    logic [15:0]       rom_dout;
    logic [15:0]       key_data;
    logic              key_valid;
    logic              key_ready;
    logic              key_last;
    logic              busy;
    logic              done;
    logic              err;

    logic [15:0] rom_mem [0:31];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int cen_low_cnt = 0;
    int addr_bad = 0;

    always #5 mclk = ~mclk;

    keyrom_reader #(.ADDR_MSB(ADDR_MSB), .KEY_WORDS(KEY_WORDS)) dut (
        .mclk          (mclk),
        .puc_rst       (puc_rst),
        .start         (start),
        .key_access_ok (key_access_ok),
        .rom_addr      (rom_addr),
        .rom_cen       (rom_cen),
        .rom_dout      (rom_dout),
        .key_data      (key_data),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .key_last      (key_last),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    // Synchronous ROM; junk when not enabled so a mistimed capture shows up.
    always @(posedge mclk) rom_dout <= rom_cen ? 16'hdead : rom_mem[rom_addr];

    always @(negedge mclk) begin
        if (rom_cen === 1'b0) cen_low_cnt++;
        if (rom_cen === 1'b1 && rom_addr !== '0) addr_bad++;
    end

    function automatic logic [15:0] exp_word(input int k);
        case (k)
            0: return 16'h0123;
            1: return 16'h4567;
            2: return 16'h89ab;
            3: return 16'hcdef;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge mclk);
        #1;
        cyc++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entered in the ISSUE cycle of word k; leaves in its OUT cycle.
    task automatic do_word(input int k);
        chk("issue_cen", rom_cen, 1'b0);
        chk("issue_addr", rom_addr, k);
        chk("issue_valid", key_valid, 1'b0);
        step();
        chk("cap_cen", rom_cen, 1'b1);
        chk("cap_valid", key_valid, 1'b0);
        step();
        chk("out_valid", key_valid, 1'b1);
        chk("out_data", key_data, exp_word(k));
        chk("out_last", key_last, (k == KEY_WORDS - 1));
        chk("out_busy", busy, 1'b1);
    endtask

    task automatic finish_stream(input int from, input bit start_in_done);
        for (int k = from; k < KEY_WORDS; k++) begin
            do_word(k);
            step();
        end
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("done_valid", key_valid, 1'b0);
        chk("done_err", err, 1'b0);
        if (start_in_done) start = 1'b1;
        step();
        start = 1'b0;
        chk("post_done", done, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("post_err", err, 1'b0);
        if (start_in_done) begin
            step();
            chk("done_start_ign_busy", busy, 1'b0);
            chk("done_start_ign_cen", rom_cen, 1'b1);
        end
    endtask

    initial begin
        int c0;
        int base;

        for (int i = 0; i < 32; i++) rom_mem[i] = 16'h0000;
        rom_mem[0] = 16'h0123;
        rom_mem[1] = 16'h4567;
        rom_mem[2] = 16'h89ab;
        rom_mem[3] = 16'hcdef;

        puc_rst       = 1'b1;
        start         = 1'b0;
        key_access_ok = 1'b1;
        key_ready     = 1'b1;
        step();
        step();
        chk("rst_cen", rom_cen, 1'b1);
        chk("rst_addr", rom_addr, 0);
        chk("rst_data", key_data, 16'h0000);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_last", key_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        puc_rst = 1'b0;
        step();

        // Full stream with latency and retention of key_data after word 3.
        c0 = cyc;
        pulse_start();
        chk("lat_issue", cyc - c0, 1);
        for (int k = 0; k < 4; k++) begin
            do_word(k);
            if (k == 0) chk("lat_first_valid", cyc - c0, 3);
            step();
        end
        chk("after_w3_data", key_data, SCRUB ? 16'h0000 : 16'hcdef);
        finish_stream(4, 1'b0);
        chk("done_lat", cyc - c0, 32);

        // Backpressure on word 2.
        pulse_start();
        do_word(0);
        step();
        do_word(1);
        step();
        do_word(2);
        key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", key_valid, 1'b1);
            chk("stall_data", key_data, 16'h89ab);
            chk("stall_cen", rom_cen, 1'b1);
        end
        key_ready = 1'b1;
        step();
        finish_stream(3, 1'b0);

        // Access dropped in OUT of word 3 with a simultaneous transfer.
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            do_word(k);
            step();
        end
        do_word(3);
        key_access_ok = 1'b0;
        base = cen_low_cnt;
        step();
        chk("abort_err", err, 1'b1);
        chk("abort_valid", key_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_data", key_data, SCRUB ? 16'h0000 : 16'hcdef);
        key_access_ok = 1'b1;
        step();
        chk("abort_err_clr", err, 1'b0);
        chk("abort_no_done", done, 1'b0);
        chk("abort_no_rom", cen_low_cnt, base);
        pulse_start();
        finish_stream(0, 1'b0);

        // Start with access denied.
        base = cen_low_cnt;
        key_access_ok = 1'b0;
        pulse_start();
        chk("deny_err", err, 1'b1);
        chk("deny_busy", busy, 1'b0);
        chk("deny_cen", rom_cen, 1'b1);
        step();
        chk("deny_err_clr", err, 1'b0);
        chk("deny_busy2", busy, 1'b0);
        chk("deny_no_rom", cen_low_cnt, base);
        key_access_ok = 1'b1;
        step();

        // Reset in CAPTURE of word 5.
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            do_word(k);
            step();
        end
        chk("w5_addr", rom_addr, 5);
        step();
        chk("w5_cap_cen", rom_cen, 1'b1);
        puc_rst = 1'b1;
        step();
        puc_rst = 1'b0;
        chk("mrst_cen", rom_cen, 1'b1);
        chk("mrst_addr", rom_addr, 0);
        chk("mrst_data", key_data, 16'h0000);
        chk("mrst_valid", key_valid, 1'b0);
        chk("mrst_last", key_last, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_err", err, 1'b0);
        step();
        chk("mrst_done2", done, 1'b0);
        chk("mrst_err2", err, 1'b0);
        chk("mrst_busy2", busy, 1'b0);

        // Fresh run with start held while busy.
        pulse_start();
        start = 1'b1;
        chk("busy_start_addr0", rom_addr, 0);
        step();
        chk("busy_start_cap", rom_cen, 1'b1);
        step();
        chk("busy_start_data0", key_data, 16'h0123);
        step();
        start = 1'b0;
        do_word(1);
        step();
        finish_stream(2, 1'b1);

        chk("addr_zero_when_disabled", addr_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
